// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative mult/div unit and HI/LO owner beside the EX-stage ALU.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave RUN once the multiplier is exhausted.
module muldiv_sequencer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [1:0]        hilo_we,
    input  logic              rd_req,
    input  logic              flush,
    output logic              busy,
    output logic              stall_req,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int W = DATA_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]     state;
    logic [1:0]     op_q;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W-1:0]   a_raw;
    logic [W-1:0]   acc_hi;
    logic [W-1:0]   acc_lo;
    logic           p_neg;
    logic           r_neg;
    logic           dbz_q;
    logic [4:0]     cnt;

    logic           is_div;
    logic           in_signed;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic [W-1:0]   mul_y;
    logic [W:0]     add_x;
    logic [W:0]     add_y;
    logic [W+1:0]   add_res;
    logic           fits;
    logic           run_last;
    logic [W-1:0]   hi_nxt;
    logic [W-1:0]   lo_nxt;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
`ifdef MULDIV_EARLY_OUT_EN
    logic [W-1:0]   mrem;
    logic [5:0]     shamt;
`endif

    assign is_div    = op_q[1];
    assign busy      = state != S_IDLE;
    assign stall_req = busy & (start | rd_req | (hilo_we != 2'b00));

    always_comb begin : operand_prep
        in_signed = ~op[0];
        a_neg     = in_signed & src_a[W-1];
        b_neg     = in_signed & src_b[W-1];
        a_abs     = a_neg ? -src_a : src_a;
        b_abs     = b_neg ? -src_b : src_b;
    end

    // One adder: add for shift-add multiply, subtract for restoring divide.
    always_comb begin : shared_adder
        mul_y   = acc_lo[0] ? a_mag : '0;
        add_x   = is_div ? {acc_hi, acc_lo[W-1]} : {1'b0, acc_hi};
        add_y   = is_div ? {1'b0, b_mag} : {1'b0, mul_y};
        add_res = {1'b0, add_x}
                + {1'b0, add_y ^ {(W+1){is_div}}}
                + {{(W+1){1'b0}}, is_div};
        fits    = add_res[W+1];
        if (is_div) begin
            hi_nxt = fits ? add_res[W-1:0] : add_x[W-1:0];
            lo_nxt = {acc_lo[W-2:0], fits};
        end else begin
            hi_nxt = add_res[W:1];
            lo_nxt = {add_res[0], acc_lo[W-1:1]};
        end
    end

    always_comb begin : run_exit
        run_last = cnt == 5'd31;
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div && mrem[W-1:1] == '0) begin
            run_last = 1'b1;
        end
`endif
    end

    // cnt holds the iteration count mod 32; an early exit leaves the
    // product partly shifted, so realign it before sign correction.
    always_comb begin : sign_fix
`ifdef MULDIV_EARLY_OUT_EN
        shamt = (cnt == 5'd0) ? 6'd0 : 6'd32 - {1'b0, cnt};
        prod  = {acc_hi, acc_lo} >> shamt;
`else
        prod  = {acc_hi, acc_lo};
`endif
        prod_fix = p_neg ? -prod : prod;
        quo_fix  = p_neg ? -acc_lo : acc_lo;
        rem_fix  = r_neg ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= 2'b00;
            a_mag       <= '0;
            b_mag       <= '0;
            a_raw       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            p_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz_q       <= 1'b0;
            cnt         <= 5'd0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            mrem        <= '0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hilo_we[1]) hi <= src_a;
                    if (hilo_we[0]) lo <= src_a;
                    if (start && !flush) begin
                        op_q  <= op;
                        a_mag <= a_abs;
                        b_mag <= b_abs;
                        a_raw <= src_a;
                        p_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        dbz_q <= op[1] & (src_b == '0);
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= '0;
                        acc_lo <= is_div ? a_mag : b_mag;
                        cnt    <= 5'd0;
`ifdef MULDIV_EARLY_OUT_EN
                        mrem   <= b_mag;
`endif
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= hi_nxt;
                        acc_lo <= lo_nxt;
                        cnt    <= cnt + 5'd1;
`ifdef MULDIV_EARLY_OUT_EN
                        mrem   <= mrem >> 1;
`endif
                        if (run_last) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div && dbz_q) begin
                            hi <= a_raw;
                            lo <= '1;
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*W-1:W];
                            lo <= prod_fix[W-1:0];
                        end
                        done        <= 1'b1;
                        div_by_zero <= is_div & dbz_q;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// Expected HI/LO/latency come from a behavioural model via a scoreboard queue.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [1:0]  hilo_we = 2'b00;
    logic        rd_req = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hilo_we(hilo_we),
        .rd_req(rd_req), .flush(flush), .busy(busy),
        .stall_req(stall_req), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [63:0] pr;
        logic [31:0] m;
        longint sa64;
        longint sb64;
        int sa;
        int sbv;
        e.dbz = 1'b0;
        e.lat = 8'd34;
        case (o)
            2'b00: begin
                sa64 = longint'($signed(a));
                sb64 = longint'($signed(b));
                pr = sa64 * sb64;
                e.hi = pr[63:32];
                e.lo = pr[31:0];
            end
            2'b01: begin
                pr = {32'b0, a} * {32'b0, b};
                e.hi = pr[63:32];
                e.lo = pr[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'd0;
                    e.lo = 32'h8000_0000;
                end else if (o == 2'b10) begin
                    sa = $signed(a);
                    sbv = $signed(b);
                    e.lo = sa / sbv;
                    e.hi = sa % sbv;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            m = (o == 2'b00 && b[31]) ? -b : b;
            e.lat = 8'd3;
            for (int i = 0; i < 32; i++)
                if (m[i]) e.lat = 8'(3 + i);
        end
`else
        m = '0;
        if (m != '0) e.lat = 8'd0;
`endif
        return e;
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input bit push);
        if (push) sb.push_back(model(o, a, b));
        op = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit seen);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, stall_req, done, div_by_zero} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {busy, stall_req, done, div_by_zero});
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic run_table(input string tag, input logic [1:0] ops[],
                             input logic [31:0] as[], input logic [31:0] bs[]);
        exp_t e;
        int lat;
        bit seen;
        for (int k = 0; k < ops.size(); k++) begin
            start_op(ops[k], as[k], bs[k], 1'b1);
            wait_done(lat, seen);
            e = sb.pop_front();
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL %s%0d.timeout: no done within bound", tag, k);
            end else begin
                checks++;
                if (lat != int'(e.lat) || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s%0d.latency: got %0d busy=%b want %0d busy=0",
                             tag, k, lat, busy, e.lat);
                end
                checks++;
                if (hi !== e.hi) begin
                    errors++;
                    $display("FAIL %s%0d.hi: got %h want %h", tag, k, hi, e.hi);
                end
                checks++;
                if (lo !== e.lo) begin
                    errors++;
                    $display("FAIL %s%0d.lo: got %h want %h", tag, k, lo, e.lo);
                end
                checks++;
                if (div_by_zero !== e.dbz) begin
                    errors++;
                    $display("FAIL %s%0d.dbz: got %b want %b", tag, k,
                             div_by_zero, e.dbz);
                end
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s%0d.pulse: done=%b dbz=%b busy=%b want 0",
                         tag, k, done, div_by_zero, busy);
            end
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    task automatic test_mult;
        logic [1:0]  o[] = '{2'b00, 2'b01, 2'b01, 2'b00};
        logic [31:0] a[] = '{32'd7, 32'hFFFF_FFFF, 32'h0000_DEAD, 32'h8000_0000};
        logic [31:0] b[] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000};
        run_table("mul", o, a, b);
    endtask

    task automatic test_div;
        logic [1:0]  o[] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
        logic [31:0] a[] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
        logic [31:0] b[] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
        run_table("div", o, a, b);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int lat;
        bit seen;
        start_op(2'b10, 32'd100, 32'hFFFF_FFF9, 1'b1);
        wait_done(lat, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL b2b_first: seen=%b got %h/%h want %h/%h",
                     seen, hi, lo, e.hi, e.lo);
        end
        // still inside the done cycle: this start must be taken
        sb.push_back(model(2'b00, 32'hFFFF_8000, 32'h0001_0003));
        op = 2'b00;
        src_a = 32'hFFFF_8000;
        src_b = 32'h0001_0003;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || lat != int'(e.lat)) begin
            errors++;
            $display("FAIL b2b_latency: seen=%b got %0d want %0d", seen, lat, e.lat);
        end
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL b2b_second: got %h/%h want %h/%h", hi, lo, e.hi, e.lo);
        end
        last_hi = e.hi;
        last_lo = e.lo;
        @(negedge clk);
    endtask

    task automatic test_flush_mthi;
        int bad;
        start_op(2'b00, 32'h55, 32'h3, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_running: busy got %b want 1", busy);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy got %b want 0", busy);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_nodone: got %0d done cycles want 0", bad);
        end
        checks++;
        if (hi !== last_hi || lo !== last_lo) begin
            errors++;
            $display("FAIL flush_hilo: got %h/%h want %h/%h", hi, lo, last_hi, last_lo);
        end
        src_a = 32'h0000_1234;
        hilo_we = 2'b10;
        @(posedge clk);
        #1 hilo_we = 2'b00;
        checks++;
        if (hi !== 32'h0000_1234 || lo !== last_lo) begin
            errors++;
            $display("FAIL mthi: got %h/%h want 00001234/%h", hi, lo, last_lo);
        end
        last_hi = 32'h0000_1234;
    endtask

    task automatic test_stall;
        exp_t e;
        int bad;
        bit seen;
        seen = 1'b0;
        bad = 0;
        start_op(2'b11, 32'd1000, 32'd7, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c >= 5 && c <= 34 && stall_req !== 1'b1) bad++;
            if (c == 35) begin
                seen = 1'b1;
                e = sb.pop_front();
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || stall_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_release: done=%b busy=%b stall=%b want 1/0/0",
                             done, busy, stall_req);
                end
                checks++;
                if (hi !== e.hi || lo !== e.lo) begin
                    errors++;
                    $display("FAIL stall_result: got %h/%h want %h/%h",
                             hi, lo, e.hi, e.lo);
                end
                last_hi = e.hi;
                last_lo = e.lo;
                rd_req = 1'b0;
                break;
            end
            if (c == 4) rd_req = 1'b1;
            if (c == 9) begin
                hilo_we = 2'b11;
                src_a = 32'hDEAD_BEEF;
            end
            if (c == 14) begin
                hilo_we = 2'b00;
                op = 2'b00;
                start = 1'b1;
            end
            if (c == 19) start = 1'b0;
        end
        checks++;
        if (!seen || bad != 0) begin
            errors++;
            $display("FAIL stall_hold: seen=%b got %0d unstalled cycles want 0", seen, bad);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_ignored_start: busy got %b want 0", busy);
        end
    endtask

    task automatic test_async_reset;
        start_op(2'b01, 32'h1234_5678, 32'h9, 1'b0);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_busy: busy=%b stall=%b want 0/0", busy, stall_req);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_hilo: got %h/%h want 0/0", hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_hi = '0;
        last_lo = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_after: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_flush_mthi();
        test_stall();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
